// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: stalls the front end while the multi-cycle mul/div unit
// works, pulses unitStart/unitAbort, and flags the cycle the result is final.
// Optional feature: define MUL_DIV_DIV_ZERO_FASTPATH_EN to resolve divide-by-zero
// in the acceptance cycle without starting the unit.
// State advances on the falling clock edge, in step with the pipeline registers.
module mul_div_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        isMulDiv,
    input  logic [2:0]  mulDivCode,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        isStructureStall,
    output logic        unitStart,
    output logic        unitAbort,
    output logic        resultValid,
    output logic        busy,
    output logic        divZeroFast
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [5:0] MUL_N = 6'(MUL_LATENCY);
    localparam logic [5:0] DIV_N = 6'(DIV_LATENCY);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] lat_n;
    logic       fast_hit;

`ifdef MUL_DIV_DIV_ZERO_FASTPATH_EN
    // Divide by zero needs no iterations: the datapath picks all-ones or op1.
    assign fast_hit = isMulDiv && !flush && mulDivCode[2] && (op2 == 32'd0);
`else
    logic unused_op2;
    assign fast_hit   = 1'b0;
    assign unused_op2 = ^op2;
`endif

    // Latency is chosen from the op class present at acceptance only.
    assign lat_n = mulDivCode[2] ? DIV_N : MUL_N;

    // State register and countdown, cleared asynchronously by reset.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake outputs; reset holds every output low.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        isStructureStall = 1'b0;
        unitStart        = 1'b0;
        unitAbort        = 1'b0;
        resultValid      = 1'b0;
        busy             = 1'b0;
        divZeroFast      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fast_hit) begin
                    divZeroFast = 1'b1;
                    resultValid = 1'b1;
                end else if (isMulDiv && !flush) begin
                    unitStart        = 1'b1;
                    isStructureStall = 1'b1;
                    if (lat_n <= 6'd1) begin
                        state_d = DONE;
                        cnt_d   = 6'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = lat_n - 6'd1;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (flush) begin
                    unitAbort = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = 6'd0;
                end else begin
                    isStructureStall = 1'b1;
                    cnt_d            = cnt_q - 6'd1;
                    if (cnt_q <= 6'd1) begin
                        state_d = DONE;
                        cnt_d   = 6'd0;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                state_d = IDLE;
                cnt_d   = 6'd0;
                if (flush) unitAbort = 1'b1;
                else       resultValid = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
        if (!rst) begin
            isStructureStall = 1'b0;
            unitStart        = 1'b0;
            unitAbort        = 1'b0;
            resultValid      = 1'b0;
            busy             = 1'b0;
            divZeroFast      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: cycle table, directed corner sequences and a
// randomized run against a transaction-level model (elapsed cycles since accept).
module tb_mul_div_sequencer;

    localparam int MUL_L = 3;
    localparam int DIV_L = 34;

    // Output vector bit masks: {stall, start, abort, resultValid, busy, divZeroFast}
    localparam logic [5:0] E_STALL = 6'b100000;
    localparam logic [5:0] E_START = 6'b010000;
    localparam logic [5:0] E_ABORT = 6'b001000;
    localparam logic [5:0] E_RV    = 6'b000100;
    localparam logic [5:0] E_BUSY  = 6'b000010;
    localparam logic [5:0] E_DZ    = 6'b000001;

`ifdef MUL_DIV_DIV_ZERO_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        isMulDiv = 1'b0;
    logic [2:0]  mulDivCode = 3'd0;
    logic [31:0] op2 = 32'd0;
    logic        flush = 1'b0;
    logic        isStructureStall, unitStart, unitAbort, resultValid, busy, divZeroFast;
    logic [5:0]  dut_v, last;

    int total = 0;
    int bad   = 0;

    // model: k = cycles elapsed since acceptance (-1 when nothing in flight)
    int k = -1, nk = -1, n = 0;

    mul_div_sequencer #(.MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L)) dut (
        .clk(clk), .rst(rst), .isMulDiv(isMulDiv), .mulDivCode(mulDivCode),
        .op2(op2), .flush(flush), .isStructureStall(isStructureStall),
        .unitStart(unitStart), .unitAbort(unitAbort), .resultValid(resultValid),
        .busy(busy), .divZeroFast(divZeroFast)
    );

    assign dut_v = {isStructureStall, unitStart, unitAbort, resultValid, busy, divZeroFast};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b (stall,start,abort,rv,busy,dz) t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic model_eval(output logic [5:0] e);
        e  = '0;
        nk = k;
        if (!rst) begin
            nk = -1;
        end else if (k < 0) begin
            nk = -1;
            if (isMulDiv && !flush) begin
                if (FAST && mulDivCode[2] && op2 == 32'd0) begin
                    e = E_DZ | E_RV;
                end else begin
                    e  = E_START | E_STALL;
                    n  = mulDivCode[2] ? DIV_L : MUL_L;
                    nk = 1;
                end
            end
        end else begin
            e = E_BUSY;
            if (flush) begin
                e  = e | E_ABORT;
                nk = -1;
            end else if (k < n) begin
                e  = e | E_STALL;
                nk = k + 1;
            end else begin
                e  = e | E_RV;
                nk = -1;
            end
        end
    endtask

    // One cycle: inputs already driven; sample mid-cycle, then cross the falling edge.
    task automatic cycle(input string nm);
        logic [5:0] e;
        model_eval(e);
        @(posedge clk);
        last = dut_v;
        chk(nm, last, e);
        @(negedge clk);
        k = nk;
        #1;
    endtask

    task automatic drive(input logic imd, input logic [2:0] c, input logic [31:0] o, input logic f);
        isMulDiv = imd; mulDivCode = c; op2 = o; flush = f;
    endtask

    typedef struct {
        logic        imd;
        logic [2:0]  code;
        logic [31:0] o2;
        logic        fl;
        logic [5:0]  exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int stalls, rvc, rvat, starts, st2, rv1, rv2, aborts;

        // reset state
        drive(1'b1, 3'd0, 32'd5, 1'b0);
        for (int i = 0; i < 3; i++) cycle("reset_hold");
        rst = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        cycle("reset_release_idle");

        // MUL timeline, flush in IDLE, flush in BUSY
        tbl[0] = '{1'b1, 3'd0, 32'd5, 1'b0, E_STALL | E_START};
        tbl[1] = '{1'b1, 3'd0, 32'd5, 1'b0, E_STALL | E_BUSY};
        tbl[2] = '{1'b1, 3'd0, 32'd5, 1'b0, E_STALL | E_BUSY};
        tbl[3] = '{1'b1, 3'd3, 32'd5, 1'b0, E_RV | E_BUSY};
        tbl[4] = '{1'b0, 3'd0, 32'd0, 1'b0, 6'b0};
        tbl[5] = '{1'b1, 3'd0, 32'd5, 1'b1, 6'b0};
        tbl[6] = '{1'b1, 3'd2, 32'd9, 1'b0, E_STALL | E_START};
        tbl[7] = '{1'b1, 3'd2, 32'd9, 1'b1, E_BUSY | E_ABORT};
        tbl[8] = '{1'b0, 3'd0, 32'd0, 1'b0, 6'b0};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].imd, tbl[i].code, tbl[i].o2, tbl[i].fl);
            cycle("tbl_model");
            chk($sformatf("tbl_row%0d", i), last, tbl[i].exp);
        end

        // DIVU op2=7: 34 stall cycles, one resultValid, then idle
        stalls = 0; rvc = 0; rvat = -1;
        for (int i = 0; i <= 36; i++) begin
            drive(i <= 34, 3'd5, 32'd7, 1'b0);
            cycle("divu");
            if (last[5]) stalls++;
            if (last[2]) begin rvc++; rvat = i; end
            if (i == 36) chk_int("divu_idle_busy", int'(last[1]), 0);
        end
        chk_int("divu_stalls", stalls, 34);
        chk_int("divu_rv_count", rvc, 1);
        chk_int("divu_rv_cycle", rvat, 34);

        // MUL then REM back to back
        stalls = 0; starts = 0; st2 = -1; rv1 = -1; rv2 = -1;
        for (int i = 0; i <= 40; i++) begin
            drive(i <= 38, (i < 4) ? 3'd0 : 3'd6, 32'd5, 1'b0);
            cycle("b2b");
            if (last[5]) stalls++;
            if (last[4]) begin starts++; if (starts == 2) st2 = i; end
            if (last[2]) begin if (rv1 < 0) rv1 = i; else rv2 = i; end
        end
        chk_int("b2b_stalls", stalls, MUL_L + DIV_L);
        chk_int("b2b_starts", starts, 2);
        chk_int("b2b_first_rv", rv1, 3);
        chk_int("b2b_second_start", st2, rv1 + 1);
        chk_int("b2b_second_rv", rv2, 38);

        // DIV flushed in cycle 10, MUL accepted in cycle 11
        aborts = 0; rvc = 0; st2 = -1; rvat = -1;
        for (int i = 0; i <= 15; i++) begin
            drive(i < 15, (i >= 11) ? 3'd0 : 3'd4, 32'd3, i == 10);
            cycle("flush");
            if (last[3]) aborts++;
            if (i == 10) begin
                chk_int("flush_abort_c10", int'(last[3]), 1);
                chk_int("flush_stall_c10", int'(last[5]), 0);
            end
            if (i <= 10 && last[2]) rvc++;
            if (i == 11) st2 = int'(last[4]);
            if (i > 10 && last[2]) rvat = i;
        end
        chk_int("flush_abort_count", aborts, 1);
        chk_int("flush_no_rv", rvc, 0);
        chk_int("flush_mul_start", st2, 1);
        chk_int("flush_mul_rv", rvat, 14);

        // reset in cycle 5 of a DIV, then a MULH
        aborts = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd4, 32'd9, 1'b0);
            cycle("rst_div");
            if (last[3]) aborts++;
        end
        rst = 1'b0;
        #1;
        chk("rst_async_zero", dut_v, 6'b0);
        cycle("rst_low");
        if (last[3]) aborts++;
        rst = 1'b1;
        st2 = -1; rvat = -1;
        for (int i = 0; i <= 4; i++) begin
            drive(i < 4, 3'd1, 32'd2, 1'b0);
            cycle("rst_mul");
            if (last[3]) aborts++;
            if (last[4]) st2 = i;
            if (last[2]) rvat = i;
        end
        chk_int("rst_no_abort", aborts, 0);
        chk_int("rst_mul_start", st2, 0);
        chk_int("rst_mul_rv", rvat, 3);

        // divide by zero
`ifdef MUL_DIV_DIV_ZERO_FASTPATH_EN
        drive(1'b1, 3'd4, 32'd0, 1'b0);
        cycle("dz_fast");
        chk("dz_fast_c0", last, E_DZ | E_RV);
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        cycle("dz_fast_after");
        chk("dz_fast_idle", last, 6'b0);
`else
        stalls = 0; rvat = -1;
        for (int i = 0; i <= 35; i++) begin
            drive(i <= 34, 3'd4, 32'd0, 1'b0);
            cycle("dz_slow");
            if (last[5]) stalls++;
            if (last[2]) rvat = i;
            if (last[0]) stalls = stalls + 100;
        end
        chk_int("dz_slow_stalls", stalls, DIV_L);
        chk_int("dz_slow_rv", rvat, DIV_L);
`endif

        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(199) != 0);
            isMulDiv   = ($urandom_range(1) == 1);
            mulDivCode = 3'($urandom_range(7));
            op2        = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            flush      = ($urandom_range(15) == 0);
            cycle("random");
        end
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
